// File: rtl/multicycle_decoder_if.sv
// Bundles the instruction fields, memory handshake and control outputs that pass
// between the multi-cycle ARM datapath and its control unit.
interface multicycle_decoder_if #(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 16
);
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic                 mem_ready;
    logic                 IRWrite;
    logic                 NextPC;
    logic                 PCS;
    logic                 RegW;
    logic                 MemW;
    logic                 NoWrite;
    logic                 AdrSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [1:0]           FlagW;
    logic                 illegal;
    logic                 instr_done;
    logic [3:0]           state_o;
    logic [CNT_W-1:0]     instr_count;

    modport master (
        output Op, Funct, Rd, mem_ready,
        input  IRWrite, NextPC, PCS, RegW, MemW, NoWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, illegal, instr_done,
               state_o, instr_count
    );

    modport slave (
        input  Op, Funct, Rd, mem_ready,
        output IRWrite, NextPC, PCS, RegW, MemW, NoWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, illegal, instr_done,
               state_o, instr_count
    );
endinterface

// File: rtl/multicycle_decoder.sv
// Control unit for the multi-cycle ARM datapath: state sequencer, ALU decoder,
// illegal-instruction detection and retired-instruction counter.
module multicycle_decoder #(
    parameter int ALUCTRL_W = 4,
    parameter int EXT_OPS   = 1,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic reset,
    multicycle_decoder_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        UNIMP  = 4'd10
    } state_t;

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;

    logic [2:0] alu_op;
    logic       legal, nowrite_dec, cv_op;

    logic       irwrite, nextpc, regw, memw, branch, nowrite, adrsrc, srca, illegal, done;
    logic [1:0] srcb, ressrc, flagw;
    logic [2:0] aluctl;

    // DP opcode decode; extended encodings fall through to illegal when disabled
    always_comb begin
        alu_op      = 3'd0;
        legal       = 1'b1;
        nowrite_dec = 1'b0;
        cv_op       = 1'b0;
        case (bus.Funct[4:1])
            4'b0100: cv_op = 1'b1;
            4'b0010: begin alu_op = 3'd1; cv_op = 1'b1; end
            4'b0000: alu_op = 3'd2;
            4'b1100: alu_op = 3'd3;
            4'b1010: begin alu_op = 3'd1; nowrite_dec = 1'b1; cv_op = 1'b1; end
            4'b0001: if (EXT_OPS != 0) alu_op = 3'd4; else legal = 1'b0;
            4'b0011: if (EXT_OPS != 0) begin alu_op = 3'd5; cv_op = 1'b1; end else legal = 1'b0;
            4'b1101: if (EXT_OPS != 0) alu_op = 3'd6; else legal = 1'b0;
            4'b1000: if (EXT_OPS != 0) begin alu_op = 3'd2; nowrite_dec = 1'b1; end
                     else legal = 1'b0;
            4'b1011: if (EXT_OPS != 0) begin nowrite_dec = 1'b1; cv_op = 1'b1; end
                     else legal = 1'b0;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt     = state;
        irwrite = 1'b0;
        nextpc  = 1'b0;
        regw    = 1'b0;
        memw    = 1'b0;
        branch  = 1'b0;
        nowrite = 1'b0;
        adrsrc  = 1'b0;
        srca    = 1'b0;
        srcb    = 2'b00;
        ressrc  = 2'b00;
        aluctl  = 3'd0;
        flagw   = 2'b00;
        illegal = 1'b0;
        done    = 1'b0;
        case (state)
            FETCH: begin
                srca = 1'b1; srcb = 2'b10; ressrc = 2'b10;
                irwrite = bus.mem_ready;
                nextpc  = bus.mem_ready;
                if (bus.mem_ready) nxt = DECODE;
            end
            DECODE: begin
                srca = 1'b1; srcb = 2'b10; ressrc = 2'b10;
                case (bus.Op)
                    2'b01:   nxt = MEMADR;
                    2'b00:   nxt = bus.Funct[5] ? EXECI : EXECR;
                    2'b10:   nxt = BRANCH;
                    default: nxt = UNIMP;
                endcase
            end
            MEMADR: begin
                srcb = 2'b01;
                nxt  = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc = 1'b1;
                if (bus.mem_ready) nxt = MEMWB;
            end
            MEMWR: begin
                adrsrc = 1'b1; memw = 1'b1;
                done   = bus.mem_ready;
                if (bus.mem_ready) nxt = FETCH;
            end
            MEMWB: begin
                ressrc = 2'b01; regw = 1'b1; done = 1'b1;
                nxt    = FETCH;
            end
            EXECR, EXECI: begin
                srcb    = (state == EXECI) ? 2'b01 : 2'b00;
                aluctl  = alu_op;
                nowrite = nowrite_dec;
                flagw   = {bus.Funct[0] & legal, bus.Funct[0] & legal & cv_op};
                illegal = !legal;
                nxt     = ALUWB;
            end
            ALUWB: begin
                nowrite = nowrite_dec;
                regw    = !nowrite_dec & legal;
                done    = 1'b1;
                nxt     = FETCH;
            end
            BRANCH: begin
                srcb = 2'b01; ressrc = 2'b10; branch = 1'b1; done = 1'b1;
                nxt  = FETCH;
            end
            UNIMP: begin
                illegal = 1'b1; done = 1'b1;
                nxt     = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (done) cnt <= cnt + CNT_W'(1);
        end
    end

    // Write enables and pulses are killed combinationally so an abort takes effect at once
    assign bus.IRWrite     = irwrite & reset;
    assign bus.NextPC      = nextpc & reset;
    assign bus.RegW        = regw & reset;
    assign bus.MemW        = memw & reset;
    assign bus.PCS         = ((bus.Rd == 4'hF) & regw | branch) & reset;
    assign bus.FlagW       = flagw & {2{reset}};
    assign bus.illegal     = illegal & reset;
    assign bus.instr_done  = done & reset;
    assign bus.NoWrite     = nowrite;
    assign bus.AdrSrc      = adrsrc;
    assign bus.ALUSrcA     = srca;
    assign bus.ALUSrcB     = srcb;
    assign bus.ResultSrc   = ressrc;
    assign bus.ALUControl  = ALUCTRL_W'(aluctl);
    assign bus.ImmSrc      = bus.Op;
    assign bus.RegSrc      = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.state_o     = state;
    assign bus.instr_count = cnt;
endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed bench for multicycle_decoder: one instance with the extended op set,
// one without, driven with identical instruction streams.
module tb_multicycle_decoder;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_decoder_if #(.ALUCTRL_W(4), .CNT_W(16)) bus1 ();
    multicycle_decoder_if #(.ALUCTRL_W(4), .CNT_W(16)) bus0 ();

    multicycle_decoder #(.ALUCTRL_W(4), .EXT_OPS(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );
    multicycle_decoder #(.ALUCTRL_W(4), .EXT_OPS(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic mr);
        bus1.Op = op; bus1.Funct = funct; bus1.Rd = rd; bus1.mem_ready = mr;
        bus0.Op = op; bus0.Funct = funct; bus0.Rd = rd; bus0.mem_ready = mr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(2'b00, 6'b101000, 4'd1, 1'b1);
        step(); step();
        chk("rst_state", bus1.state_o, 0);
        chk("rst_irwrite", bus1.IRWrite, 0);
        chk("rst_nextpc", bus1.NextPC, 0);
        chk("rst_count", bus1.instr_count, 0);
        chk("rst_done", bus1.instr_done, 0);

        // ADD immediate
        reset = 1'b1; #1;
        chk("add_fetch_state", bus1.state_o, 0);
        chk("add_fetch_irwrite", bus1.IRWrite, 1);
        chk("add_fetch_nextpc", bus1.NextPC, 1);
        chk("add_fetch_srcb", bus1.ALUSrcB, 2);
        chk("add_fetch_res", bus1.ResultSrc, 2);
        step();
        chk("add_decode_state", bus1.state_o, 1);
        chk("add_decode_regw", bus1.RegW, 0);
        step();
        chk("add_execi_state", bus1.state_o, 7);
        chk("add_execi_srcb", bus1.ALUSrcB, 1);
        chk("add_execi_alu", bus1.ALUControl, 0);
        chk("add_execi_flagw", bus1.FlagW, 0);
        chk("add_execi_regw", bus1.RegW, 0);
        step();
        chk("add_aluwb_state", bus1.state_o, 8);
        chk("add_aluwb_regw", bus1.RegW, 1);
        chk("add_aluwb_done", bus1.instr_done, 1);
        chk("add_aluwb_pcs", bus1.PCS, 0);
        chk("add_aluwb_count", bus1.instr_count, 0);
        step();
        chk("add_end_state", bus1.state_o, 0);
        chk("add_end_count", bus1.instr_count, 1);

        // LDR with memory stall
        drive(2'b01, 6'b011001, 4'd2, 1'b1);
        chk("ldr_regsrc", bus1.RegSrc, 2);
        step();
        chk("ldr_decode_state", bus1.state_o, 1);
        step();
        chk("ldr_memadr_state", bus1.state_o, 2);
        chk("ldr_memadr_srcb", bus1.ALUSrcB, 1);
        step();
        drive(2'b01, 6'b011001, 4'd2, 1'b0);
        chk("ldr_memrd_state1", bus1.state_o, 3);
        chk("ldr_memrd_adrsrc", bus1.AdrSrc, 1);
        step();
        chk("ldr_memrd_state2", bus1.state_o, 3);
        step();
        chk("ldr_memrd_state3", bus1.state_o, 3);
        step();
        chk("ldr_memrd_state4", bus1.state_o, 3);
        drive(2'b01, 6'b011001, 4'd2, 1'b1);
        step();
        chk("ldr_memwb_state", bus1.state_o, 4);
        chk("ldr_memwb_regw", bus1.RegW, 1);
        chk("ldr_memwb_res", bus1.ResultSrc, 1);
        chk("ldr_memwb_done", bus1.instr_done, 1);
        step();
        chk("ldr_end_count", bus1.instr_count, 2);

        // STR with memory stall
        drive(2'b01, 6'b011000, 4'd2, 1'b1);
        step(); step(); step();
        drive(2'b01, 6'b011000, 4'd2, 1'b0);
        chk("str_memwr_state", bus1.state_o, 5);
        chk("str_memw1", bus1.MemW, 1);
        chk("str_done1", bus1.instr_done, 0);
        step();
        chk("str_memw2", bus1.MemW, 1);
        chk("str_done2", bus1.instr_done, 0);
        step();
        drive(2'b01, 6'b011000, 4'd2, 1'b1);
        chk("str_memw3", bus1.MemW, 1);
        chk("str_done3", bus1.instr_done, 1);
        step();
        chk("str_end_state", bus1.state_o, 0);
        chk("str_end_memw", bus1.MemW, 0);
        chk("str_end_count", bus1.instr_count, 3);

        // CMP register, S=1
        drive(2'b00, 6'b010101, 4'd3, 1'b1);
        step(); step();
        chk("cmp_execr_state", bus1.state_o, 6);
        chk("cmp_execr_alu", bus1.ALUControl, 1);
        chk("cmp_execr_flagw", bus1.FlagW, 3);
        chk("cmp_execr_nowrite", bus1.NoWrite, 1);
        chk("cmp_execr_srcb", bus1.ALUSrcB, 0);
        step();
        chk("cmp_aluwb_regw", bus1.RegW, 0);
        chk("cmp_aluwb_nowrite", bus1.NoWrite, 1);
        chk("cmp_aluwb_done", bus1.instr_done, 1);
        step();
        chk("cmp_end_count", bus1.instr_count, 4);

        // EOR with S=1: legal only with the extended op set
        drive(2'b00, 6'b000011, 4'd4, 1'b1);
        step(); step();
        chk("eor1_alu", bus1.ALUControl, 4);
        chk("eor1_flagw", bus1.FlagW, 2);
        chk("eor1_illegal", bus1.illegal, 0);
        chk("eor0_alu", bus0.ALUControl, 0);
        chk("eor0_flagw", bus0.FlagW, 0);
        chk("eor0_illegal", bus0.illegal, 1);
        step();
        chk("eor1_regw", bus1.RegW, 1);
        chk("eor0_regw", bus0.RegW, 0);
        chk("eor0_illegal_wb", bus0.illegal, 0);
        step();
        chk("eor1_count", bus1.instr_count, 5);
        chk("eor0_count", bus0.instr_count, 5);

        // ADD writing R15 raises PCS
        drive(2'b00, 6'b101000, 4'hF, 1'b1);
        step(); step(); step();
        chk("r15_regw", bus1.RegW, 1);
        chk("r15_pcs", bus1.PCS, 1);
        step();
        chk("r15_count", bus1.instr_count, 6);

        // Branch
        drive(2'b10, 6'b000000, 4'd0, 1'b1);
        step(); step();
        chk("b_state", bus1.state_o, 9);
        chk("b_pcs", bus1.PCS, 1);
        chk("b_srcb", bus1.ALUSrcB, 1);
        chk("b_res", bus1.ResultSrc, 2);
        chk("b_regsrc", bus1.RegSrc, 1);
        chk("b_immsrc", bus1.ImmSrc, 2);
        chk("b_done", bus1.instr_done, 1);
        step();
        chk("b_end_pcs", bus1.PCS, 0);
        chk("b_end_count", bus1.instr_count, 7);

        // Op=11 is unimplemented
        drive(2'b11, 6'b000000, 4'd0, 1'b1);
        step(); step();
        chk("unimp_state", bus1.state_o, 10);
        chk("unimp_illegal", bus1.illegal, 1);
        chk("unimp_done", bus1.instr_done, 1);
        step();
        chk("unimp_end_illegal", bus1.illegal, 0);
        chk("unimp_end_count", bus1.instr_count, 8);

        // Reset dropped in the middle of a store
        drive(2'b01, 6'b011000, 4'd2, 1'b1);
        step(); step(); step();
        drive(2'b01, 6'b011000, 4'd2, 1'b0);
        chk("abort_memw_before", bus1.MemW, 1);
        reset = 1'b0; #1;
        chk("abort_memw", bus1.MemW, 0);
        chk("abort_state", bus1.state_o, 0);
        chk("abort_count", bus1.instr_count, 0);
        step();
        reset = 1'b1;
        drive(2'b01, 6'b011000, 4'd2, 1'b0);
        chk("release_state", bus1.state_o, 0);
        chk("release_irwrite", bus1.IRWrite, 0);
        step();
        chk("fetch_hold_state", bus1.state_o, 0);
        drive(2'b01, 6'b011000, 4'd2, 1'b1);
        step();
        chk("fetch_go_state", bus1.state_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
